bram_18_14_arb: RTL
===================

Name: bram_18_14_arb

Overview:
- Shares one 18-bit x 16384-entry simple-dual-port BRAM (independent write port, independent read port, registered addresses, 1-cycle read latency) among N_CLIENT requesters in the NTT datapath, e.g. the butterfly unit, input loader and output drainer.
- Arbitrates the write port and the read port independently, each with its own round-robin pointer.
- Returns read data to the winning client with a valid strobe one cycle after its grant.
- Sits between the NTT clients and the BRAM instance; it is the only driver of the BRAM ports.

Parameters:
- N_CLIENT, 2, number of requesters; legal range 2..4.
- ADDR_W, 14, BRAM address width.
- DATA_W, 18, BRAM data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- wr_req  in  N_CLIENT  per-client write request.
- wr_addr  in  N_CLIENT*ADDR_W  per-client write address; client i uses slice i.
- wr_data  in  N_CLIENT*DATA_W  per-client write data.
- wr_gnt  out  N_CLIENT  one-hot write grant; the write is taken in the cycle wr_req&wr_gnt.
- rd_req  in  N_CLIENT  per-client read request.
- rd_addr  in  N_CLIENT*ADDR_W  per-client read address.
- rd_gnt  out  N_CLIENT  one-hot read grant; the read is taken in the cycle rd_req&rd_gnt.
- rsp_valid  out  N_CLIENT  one-hot; rsp_valid[i] is high the cycle after rd_gnt[i].
- rsp_data  out  DATA_W  read data, meaningful only while any rsp_valid bit is high.
- bram_wr_en  out  1  BRAM write enable.
- bram_wr_addr  out  ADDR_W  BRAM write address.
- bram_wr_din  out  DATA_W  BRAM write data.
- bram_rd_addr  out  ADDR_W  BRAM read address.
- bram_rd_dout  in  DATA_W  BRAM read data, valid the cycle after bram_rd_addr is presented.

Behaviour:
- Grant logic:
  - Grants are combinational from the requests and the registered pointers.
  - Winner is the first requesting index found searching upward (modulo N_CLIENT) from the pointer.
  - At most one grant bit per port per cycle. No grant is issued without a request.
- Pointer update: on a granted cycle the pointer becomes (winner+1) mod N_CLIENT; with no grant it holds. Write and read pointers are separate registers.
- Write path:
  - bram_wr_en = |(wr_req&wr_gnt).
  - bram_wr_addr and bram_wr_din are muxed from the winner's slice; they are 0 when no write is granted.
- Read path:
  - bram_rd_addr is muxed from the read winner; it holds its last value when there is no read grant.
  - A registered one-hot rsp_sel captures rd_gnt each cycle; rsp_valid = rsp_sel.
  - rsp_data = bram_rd_dout, passed through combinationally.
- Latency: request to grant 0 cycles, grant to rsp_valid 1 cycle. Throughput is one write plus one read per cycle.
- No response back-pressure: clients must accept rsp_valid in the cycle it is high.
- Same-address read and write in the same cycle: the response carries the NEW data, since the BRAM write commits on the same edge that registers the read address. No bypass logic is needed.
- Requests may change freely while ungranted. A client that drops its request before being granted loses nothing.
- Reset (rst_n low at a clk edge):
  - Both pointers go to 0 and rsp_sel goes to 0.
  - While rst_n is low, wr_gnt, rd_gnt and bram_wr_en are forced to 0.
  - A read granted in the cycle before reset produces no rsp_valid.
- Single requester: it is granted every cycle, back to back.
- Pointer wrap: from N_CLIENT-1 the pointer wraps to 0.

Decomposition:
- Shared package holds ADDR_W=14, DATA_W=18, the maximum N_CLIENT=4, and a onehot-to-index function.
- Sub-module rr_arb_n: a parameterised round-robin arbiter with req, gnt and a registered pointer. It is instantiated twice, once for the write port and once for the read port.
- The top level contains the muxes and the rsp_sel register.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with all requests high -> all grants 0, bram_wr_en 0, rsp_valid 0. After release, the first grants are wr_gnt=01 and rd_gnt=01.
- Round-robin alternation: N_CLIENT=2, both clients request writes continuously with addr 0x0010 and 0x0020 -> wr_gnt alternates 01,10,01,10 and bram_wr_addr alternates 0x0010,0x0020.
- Read latency and tagging: client1 reads addr 0x3FFF, which was preloaded with 0x2ABCD -> the cycle after rd_gnt=10, rsp_valid=10 and rsp_data=0x2ABCD.
- Same-cycle collision: in one cycle client0 writes 0x1F00F to 0x0100 while client1 reads 0x0100 -> the next cycle rsp_valid=10 and rsp_data=0x1F00F.
- Reset mid-operation: rd_gnt=01 at cycle t, rst_n=0 at cycle t+1 -> rsp_valid stays 0, and the pointers read 0 after release.
- Dropped request and wrap: N_CLIENT=3, request pattern 111 then 101 then 111 -> rd_gnt sequence 001,100,001 (pointer wraps from 2 to 0). A client that toggles its request off while ungranted receives no stray grant.

Source files
------------

// File: rtl/bram_18_14_arb_pkg.sv
// Shared constants and helpers for the NTT BRAM port arbiter.
package bram_18_14_arb_pkg;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned DATA_W     = 18;
    localparam int unsigned MAX_CLIENT = 4;
    localparam int unsigned IDX_W      = $clog2(MAX_CLIENT);

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CLIENT-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CLIENT; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bram_18_14_arb_rr_arb_n.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arb_n #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;
    logic          found;

    // Search upward from the pointer, modulo N; first requester wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PW'((32'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                ptr_d     = PW'((32'(cand) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_18_14_arb.sv
// Shares one simple-dual-port BRAM among N_CLIENT requesters with independent
// round-robin arbitration of the write and read ports.
module bram_18_14_arb #(
    parameter int unsigned N_CLIENT = 2,
    parameter int unsigned ADDR_W   = bram_18_14_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = bram_18_14_arb_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CLIENT-1:0]          wr_req,
    input  logic [N_CLIENT*ADDR_W-1:0]   wr_addr,
    input  logic [N_CLIENT*DATA_W-1:0]   wr_data,
    output logic [N_CLIENT-1:0]          wr_gnt,
    input  logic [N_CLIENT-1:0]          rd_req,
    input  logic [N_CLIENT*ADDR_W-1:0]   rd_addr,
    output logic [N_CLIENT-1:0]          rd_gnt,
    output logic [N_CLIENT-1:0]          rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         bram_wr_en,
    output logic [ADDR_W-1:0]            bram_wr_addr,
    output logic [DATA_W-1:0]            bram_wr_din,
    output logic [ADDR_W-1:0]            bram_rd_addr,
    input  logic [DATA_W-1:0]            bram_rd_dout
);

    import bram_18_14_arb_pkg::*;

    logic [N_CLIENT-1:0]   wr_req_m, rd_req_m;
    logic [MAX_CLIENT-1:0] wr_oh, rd_oh;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  rd_any;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [N_CLIENT-1:0]   rsp_sel_q;

    // Masking requests keeps every grant low while reset is asserted.
    assign wr_req_m = wr_req & {N_CLIENT{rst_n}};
    assign rd_req_m = rd_req & {N_CLIENT{rst_n}};

    rr_arb_n #(.N(N_CLIENT)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req_m),
        .gnt   (wr_gnt)
    );

    rr_arb_n #(.N(N_CLIENT)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req_m),
        .gnt   (rd_gnt)
    );

    always_comb begin
        wr_oh                 = '0;
        rd_oh                 = '0;
        wr_oh[N_CLIENT-1:0]   = wr_gnt;
        rd_oh[N_CLIENT-1:0]   = rd_gnt;
    end

    assign wr_idx = onehot_to_idx(wr_oh);
    assign rd_idx = onehot_to_idx(rd_oh);

    assign bram_wr_en = |(wr_req & wr_gnt);

    always_comb begin
        bram_wr_addr = '0;
        bram_wr_din  = '0;
        if (bram_wr_en) begin
            bram_wr_addr = wr_addr[wr_idx*ADDR_W +: ADDR_W];
            bram_wr_din  = wr_data[wr_idx*DATA_W +: DATA_W];
        end
    end

    // Read address holds its last value on idle cycles.
    assign rd_any       = |(rd_req & rd_gnt);
    assign bram_rd_addr = rd_any ? rd_addr[rd_idx*ADDR_W +: ADDR_W] : rd_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rsp_sel_q <= '0;
        end else begin
            rd_addr_q <= bram_rd_addr;
            rsp_sel_q <= rd_gnt;
        end
    end

    // A response in flight when reset arrives is dropped.
    assign rsp_valid = rsp_sel_q & {N_CLIENT{rst_n}};
    assign rsp_data  = bram_rd_dout;

endmodule
